alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one ALU between two requesters using round-robin arbitration.
- Captures the winning requester's operands and function code, drives them to the ALU, and waits for the ALU's registered result.
- Returns the result, tagged with the requester ID, and flags an error if the ALU does not answer within a timeout.
- Sits between the system-control requesters and the ALU. The ALU's internal unit decoder consumes ALU_FUN[3:2].

Parameters:
- DATA_WIDTH, 8, operand width.
- OUT_WIDTH, 16, ALU result width.
- TIMEOUT, 15, maximum WAIT cycles before an error response. Legal range 1..255.

Ports:
- CLK, in, 1, system clock.
- RST, in, 1, asynchronous active-high reset.
- REQ0, in, 1, requester 0 request. Level signal, held until GNT0.
- A0, B0, in, DATA_WIDTH each, requester 0 operands.
- FUN0, in, 4, requester 0 function code.
- REQ1, A1, B1, FUN1, in, same widths as requester 0, requester 1 equivalents.
- GNT0, GNT1, out, 1, one-cycle accept pulses.
- RES_VALID, out, 1, one-cycle result pulse.
- RES_ID, out, 1, requester that owns the result.
- RES_DATA, out, OUT_WIDTH, result value.
- RES_ERR, out, 1, timeout flag, qualified by RES_VALID.
- BUSY, out, 1, high while an operation is outstanding.
- ALU_A, ALU_B, out, DATA_WIDTH each, operands to the ALU.
- ALU_FUN, out, 4, function code to the ALU.
- ALU_EN, out, 1, one-cycle ALU enable.
- ALU_OUT, in, OUT_WIDTH, ALU result.
- ALU_OUT_VALID, in, 1, ALU result valid.

Behaviour:
- Clocking and reset:
  - Single clock, CLK.
  - RST is asynchronous, active-high.
  - All outputs are registered.
- Reset values:
  - State = IDLE.
  - GNT0, GNT1, ALU_EN, RES_VALID, RES_ERR, RES_ID, BUSY = 0.
  - ALU_A, ALU_B, ALU_FUN, RES_DATA = 0.
  - Timer = 0.
  - Round-robin pointer LAST = 1, so requester 0 wins first.
- States: IDLE and WAIT.
- IDLE transitions:
  - No request: stay in IDLE. GNTx, ALU_EN and RES_VALID are 0.
  - Only REQx high: x wins.
  - Both requests high: the winner is the requester ≠ LAST.
  - On the edge that sees the winner:
    - ALU_A/B/FUN load the winner's Ax/Bx/FUNx.
    - GNTx = 1 and ALU_EN = 1, each for exactly one cycle.
    - Grant ID is stored; LAST = winner.
    - Timer = 0, BUSY = 1, state = WAIT.
- WAIT behaviour:
  - GNTx and ALU_EN return to 0.
  - ALU_A/B/FUN hold their values.
  - Timer increments by 1 each cycle.
  - REQ0 and REQ1 are ignored; new requests are not queued.
- WAIT exit on a result:
  - Condition: ALU_OUT_VALID = 1 is sampled.
  - Next cycle: RES_VALID = 1, RES_DATA = ALU_OUT, RES_ID = grant ID, RES_ERR = 0.
  - BUSY = 0, state = IDLE.
- WAIT exit on timeout:
  - Condition: timer == TIMEOUT and ALU_OUT_VALID = 0.
  - Next cycle: RES_VALID = 1, RES_ERR = 1, RES_DATA = 0, RES_ID = grant ID.
  - BUSY = 0, state = IDLE.
  - On the same edge as the timeout, ALU_OUT_VALID = 1 wins: a normal result is returned.
- ALU_OUT_VALID is ignored in IDLE, including late results after a timeout.
- Requester rules:
  - A requester drops REQx in the cycle GNTx is high.
  - A REQx still high once the arbiter is back in IDLE is treated as a new request.
- RES_DATA, RES_ID and RES_ERR hold their values until the next response. RES_VALID is a pulse.
- Latency with a one-cycle ALU:
  - REQ sampled at edge t → GNT/ALU_EN during cycle t.
  - ALU_OUT_VALID during cycle t+1 → RES_VALID during cycle t+2.
- Back-to-back operation:
  - The arbiter returns to IDLE on the same edge that raises RES_VALID.
  - A pending request is therefore granted on the following edge.
  - Minimum spacing between successive grants is 3 cycles.
- Fairness: with both requesters continuously requesting, grants alternate 0, 1, 0, 1, ...
- Reset mid-operation:
  - Outstanding operation is discarded, with no response.
  - All registers return to reset values immediately, without waiting for CLK.

Test Plan:
- Reset, then REQ0 with A0=8'h12, B0=8'h34, FUN0=4'b0000 (add), 1-cycle ALU model → GNT0 pulse; ALU_A=12, ALU_B=34; RES_VALID 2 cycles after GNT0 with RES_DATA=16'h0046, RES_ID=0, RES_ERR=0.
- REQ0 and REQ1 both held high for 4 operations → grant order 0, 1, 0, 1; each RES_ID matches its grant; grants 3 cycles apart.
- Only REQ1 active after reset → GNT1 despite LAST=1; a subsequent simultaneous request grants 0.
- ALU model never asserts valid, TIMEOUT=15 → RES_VALID with RES_ERR=1 and RES_DATA=0 exactly 16 cycles after ALU_EN; a late ALU_OUT_VALID afterwards is ignored.
- ALU_OUT_VALID arriving on the timeout edge with ALU_OUT=16'h00AA → RES_ERR=0, RES_DATA=16'h00AA.
- RST asserted asynchronously mid-WAIT → BUSY=0 and GNT=0 immediately, no RES_VALID; the next REQ1 is granted normally.

Source files
------------

// File: rtl/alu_rr_arbiter_if.sv
// Bundle between the requesters, the shared ALU and the arbiter.
// master = requester/ALU side, slave = arbiter side.
interface alu_rr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16
);
  logic                  REQ0;
  logic [DATA_WIDTH-1:0] A0;
  logic [DATA_WIDTH-1:0] B0;
  logic [3:0]            FUN0;
  logic                  REQ1;
  logic [DATA_WIDTH-1:0] A1;
  logic [DATA_WIDTH-1:0] B1;
  logic [3:0]            FUN1;
  logic                  GNT0;
  logic                  GNT1;
  logic                  RES_VALID;
  logic                  RES_ID;
  logic [OUT_WIDTH-1:0]  RES_DATA;
  logic                  RES_ERR;
  logic                  BUSY;
  logic [DATA_WIDTH-1:0] ALU_A;
  logic [DATA_WIDTH-1:0] ALU_B;
  logic [3:0]            ALU_FUN;
  logic                  ALU_EN;
  logic [OUT_WIDTH-1:0]  ALU_OUT;
  logic                  ALU_OUT_VALID;

  modport master (
    output REQ0, A0, B0, FUN0,
    output REQ1, A1, B1, FUN1,
    output ALU_OUT, ALU_OUT_VALID,
    input  GNT0, GNT1,
    input  RES_VALID, RES_ID, RES_DATA, RES_ERR,
    input  BUSY,
    input  ALU_A, ALU_B, ALU_FUN, ALU_EN
  );

  modport slave (
    input  REQ0, A0, B0, FUN0,
    input  REQ1, A1, B1, FUN1,
    input  ALU_OUT, ALU_OUT_VALID,
    output GNT0, GNT1,
    output RES_VALID, RES_ID, RES_DATA, RES_ERR,
    output BUSY,
    output ALU_A, ALU_B, ALU_FUN, ALU_EN
  );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Ports: CLK, RST (async high), bus (slave side of alu_rr_arbiter_if).
module alu_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic           CLK,
  input  logic           RST,
  alu_rr_arbiter_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic                  gid_q, gid_d;
  logic [7:0]            timer_q, timer_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  en_q, en_d;
  logic                  rv_q, rv_d;
  logic                  err_q, err_d;
  logic                  id_q, id_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [3:0]            fun_q, fun_d;
  logic [OUT_WIDTH-1:0]  data_q, data_d;

  logic both;
  logic win_vld;
  logic win_id;

  // Winner select: on contention the side that did not win last.
  always_comb begin
    both    = bus.REQ0 & bus.REQ1;
    win_vld = bus.REQ0 | bus.REQ1;
    unique case (1'b1)
      both:                   win_id = ~last_q;
      (bus.REQ1 & ~bus.REQ0): win_id = 1'b1;
      default:                win_id = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    timer_d = timer_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    en_d    = 1'b0;
    rv_d    = 1'b0;
    err_d   = err_q;
    id_d    = id_q;
    busy_d  = busy_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          a_d     = win_id ? bus.A1 : bus.A0;
          b_d     = win_id ? bus.B1 : bus.B0;
          fun_d   = win_id ? bus.FUN1 : bus.FUN0;
          gnt0_d  = ~win_id;
          gnt1_d  = win_id;
          en_d    = 1'b1;
          gid_d   = win_id;
          last_d  = win_id;
          timer_d = '0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result on the timeout edge still counts as a result.
        if (bus.ALU_OUT_VALID) begin
          rv_d    = 1'b1;
          data_d  = bus.ALU_OUT;
          id_d    = gid_q;
          err_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (timer_q == TMO) begin
          rv_d    = 1'b1;
          data_d  = '0;
          id_d    = gid_q;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      timer_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      en_q    <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      id_q    <= 1'b0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      timer_q <= timer_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      data_q  <= data_d;
    end
  end

  assign bus.GNT0      = gnt0_q;
  assign bus.GNT1      = gnt1_q;
  assign bus.ALU_EN    = en_q;
  assign bus.ALU_A     = a_q;
  assign bus.ALU_B     = b_q;
  assign bus.ALU_FUN   = fun_q;
  assign bus.RES_VALID = rv_q;
  assign bus.RES_ERR   = err_q;
  assign bus.RES_ID    = id_q;
  assign bus.RES_DATA  = data_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: transaction-level model plus directed
// scenarios and randomized requesters / ALU latency.
module tb_alu_rr_arbiter;
  localparam int DW  = 8;
  localparam int OW  = 16;
  localparam int TMO = 15;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  alu_rr_arbiter_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

  alu_rr_arbiter #(
    .DATA_WIDTH(DW),
    .OUT_WIDTH(OW),
    .TIMEOUT(TMO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An operation opened at cycle g ends at the first later edge that
  // sees ALU_OUT_VALID, or with an error at edge g+TMO+1.
  int         cyc     = 0;
  bit         m_busy  = 0;
  bit         m_last  = 1;
  bit         m_owner = 0;
  bit         m_win;
  int         m_gcyc  = 0;
  logic       e_gnt0 = 0, e_gnt1 = 0, e_en = 0, e_rv = 0;
  logic       e_err = 0, e_id = 0, e_busy = 0;
  logic [7:0] e_a = 0, e_b = 0;
  logic [3:0] e_fun = 0;
  logic [15:0] e_data = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy = 0; m_last = 1; m_owner = 0;
      e_gnt0 = 0; e_gnt1 = 0; e_en = 0; e_rv = 0;
      e_err = 0; e_id = 0; e_busy = 0;
      e_a = 0; e_b = 0; e_fun = 0; e_data = 0;
    end else begin
      cyc++;
      e_gnt0 = 0; e_gnt1 = 0; e_en = 0; e_rv = 0;
      if (!m_busy) begin
        if (bus.REQ0 || bus.REQ1) begin
          m_win   = (bus.REQ0 && bus.REQ1) ? !m_last : bus.REQ1;
          m_last  = m_win;
          m_owner = m_win;
          m_busy  = 1;
          m_gcyc  = cyc;
          e_gnt0  = !m_win;
          e_gnt1  = m_win;
          e_en    = 1;
          e_a     = m_win ? bus.A1 : bus.A0;
          e_b     = m_win ? bus.B1 : bus.B0;
          e_fun   = m_win ? bus.FUN1 : bus.FUN0;
          e_busy  = 1;
        end
      end else if (bus.ALU_OUT_VALID) begin
        m_busy = 0; e_busy = 0; e_rv = 1;
        e_err = 0; e_id = m_owner; e_data = bus.ALU_OUT;
      end else if (cyc - m_gcyc == TMO + 1) begin
        m_busy = 0; e_busy = 0; e_rv = 1;
        e_err = 1; e_id = m_owner; e_data = 0;
      end
    end
  end

  always @(negedge CLK) begin
    chk("gnt0", bus.GNT0, e_gnt0);
    chk("gnt1", bus.GNT1, e_gnt1);
    chk("alu_en", bus.ALU_EN, e_en);
    chk("alu_a", bus.ALU_A, e_a);
    chk("alu_b", bus.ALU_B, e_b);
    chk("alu_fun", bus.ALU_FUN, e_fun);
    chk("res_valid", bus.RES_VALID, e_rv);
    chk("res_err", bus.RES_ERR, e_err);
    chk("res_id", bus.RES_ID, e_id);
    chk("res_data", bus.RES_DATA, e_data);
    chk("busy", bus.BUSY, e_busy);
  end

  // ---------------- ALU model ----------------
  // Latency L: valid is sampled by the arbiter L+1 edges after the
  // grant edge. L = 0 means the ALU never answers.
  int         alu_lat  = 1;
  bit         alu_rand = 0;
  int         alu_cnt  = 0;
  logic [7:0] la = 0, lb = 0;
  logic [3:0] lf = 0;

  function automatic logic [15:0] alu_f(logic [7:0] a, logic [7:0] b,
                                        logic [3:0] f);
    case (f)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      default: return {a ^ b, 4'(f), 4'(a[3:0])};
    endcase
  endfunction

  function automatic int pick_lat();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 15;
      2:       return 16;
      3:       return int'($urandom_range(4, 20));
      default: return int'($urandom_range(1, 3));
    endcase
  endfunction

  initial begin
    bus.ALU_OUT       = '0;
    bus.ALU_OUT_VALID = 1'b0;
  end

  always @(negedge CLK) begin
    bus.ALU_OUT_VALID = 1'b0;
    if (RST) begin
      alu_cnt = 0;
    end else begin
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          bus.ALU_OUT_VALID = 1'b1;
          bus.ALU_OUT       = alu_f(la, lb, lf);
        end
      end
      if (bus.ALU_EN === 1'b1) begin
        la = bus.ALU_A;
        lb = bus.ALU_B;
        lf = bus.ALU_FUN;
        alu_cnt = alu_rand ? pick_lat() : alu_lat;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_gnt(output int who, output bit ok);
    ok  = 0;
    who = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (bus.GNT0 || bus.GNT1) begin
        ok  = 1;
        who = bus.GNT1 ? 1 : 0;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL gnt_wait actual=none required=grant");
    end
  endtask

  task automatic wait_res(output bit ok);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (bus.RES_VALID) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL res_wait actual=none required=res_valid");
    end
  endtask

  task automatic set_req(int id, logic [7:0] a, logic [7:0] b,
                         logic [3:0] f);
    if (id == 0) begin
      bus.REQ0 = 1; bus.A0 = a; bus.B0 = b; bus.FUN0 = f;
    end else begin
      bus.REQ1 = 1; bus.A1 = a; bus.B1 = b; bus.FUN1 = f;
    end
  endtask

  task automatic drop_req(int id);
    if (id == 0) bus.REQ0 = 0;
    else         bus.REQ1 = 0;
  endtask

  // ---------------- stimulus ----------------
  int who;
  bit ok;
  int g;
  int prev;

  initial begin
    bus.REQ0 = 0; bus.A0 = 0; bus.B0 = 0; bus.FUN0 = 0;
    bus.REQ1 = 0; bus.A1 = 0; bus.B1 = 0; bus.FUN1 = 0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_gnt", {bus.GNT1, bus.GNT0}, 0);
    chk("rst_en", bus.ALU_EN, 0);
    chk("rst_rv", bus.RES_VALID, 0);
    chk("rst_data", bus.RES_DATA, 0);
    chk("rst_alu_a", bus.ALU_A, 0);
    RST = 0;

    // single add from requester 0
    alu_lat = 1;
    set_req(0, 8'h12, 8'h34, 4'b0000);
    wait_gnt(who, ok);
    g = cyc;
    chk("t1_who", who, 0);
    chk("t1_alu_a", bus.ALU_A, 8'h12);
    chk("t1_alu_b", bus.ALU_B, 8'h34);
    chk("t1_en", bus.ALU_EN, 1);
    drop_req(0);
    wait_res(ok);
    chk("t1_lat", cyc - g, 2);
    chk("t1_data", bus.RES_DATA, 16'h0046);
    chk("t1_id", bus.RES_ID, 0);
    chk("t1_err", bus.RES_ERR, 0);

    // fresh reset, only requester 1
    @(negedge CLK);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    set_req(1, 8'h05, 8'h07, 4'b0000);
    wait_gnt(who, ok);
    chk("t3_who", who, 1);
    drop_req(1);
    wait_res(ok);
    chk("t3_data", bus.RES_DATA, 16'h000C);
    chk("t3_id", bus.RES_ID, 1);

    // both held: alternate 0,1,0,1 three cycles apart
    set_req(0, 8'h21, 8'h03, 4'd1);
    set_req(1, 8'h11, 8'h04, 4'd2);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(who, ok);
      chk("t2_order", who, k % 2);
      if (k > 0) chk("t2_space", cyc - prev, 3);
      prev = cyc;
      drop_req(who);
      @(negedge CLK);
      if (k < 3) set_req(who, 8'(k + 3), 8'(k + 9), 4'(k));
    end
    drop_req(0);
    drop_req(1);
    wait_res(ok);
    chk("t2_last_id", bus.RES_ID, 1);

    // timeout, then a late result that must be ignored
    @(negedge CLK);
    alu_lat = 16;
    set_req(0, 8'h01, 8'h02, 4'd0);
    wait_gnt(who, ok);
    g = cyc;
    chk("t4_en", bus.ALU_EN, 1);
    drop_req(0);
    wait_res(ok);
    chk("t4_lat", cyc - g, TMO + 1);
    chk("t4_err", bus.RES_ERR, 1);
    chk("t4_data", bus.RES_DATA, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("t4_late_rv", bus.RES_VALID, 0);
      chk("t4_late_busy", bus.BUSY, 0);
    end

    // result arriving on the timeout edge
    alu_lat = 15;
    set_req(1, 8'hA0, 8'h0A, 4'd0);
    wait_gnt(who, ok);
    g = cyc;
    drop_req(who);
    wait_res(ok);
    chk("t5_lat", cyc - g, TMO + 1);
    chk("t5_err", bus.RES_ERR, 0);
    chk("t5_data", bus.RES_DATA, 16'h00AA);

    // async reset in the middle of WAIT
    @(negedge CLK);
    alu_lat = 0;
    set_req(0, 8'h33, 8'h44, 4'd0);
    wait_gnt(who, ok);
    drop_req(0);
    repeat (4) @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1;
    #1;
    chk("t6_busy", bus.BUSY, 0);
    chk("t6_gnt", {bus.GNT1, bus.GNT0}, 0);
    chk("t6_en", bus.ALU_EN, 0);
    @(negedge CLK);
    RST = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      chk("t6_no_rv", bus.RES_VALID, 0);
    end
    alu_lat = 1;
    set_req(1, 8'h10, 8'h20, 4'd0);
    wait_gnt(who, ok);
    chk("t6_who", who, 1);
    drop_req(1);
    wait_res(ok);
    chk("t6_data", bus.RES_DATA, 16'h0030);
    chk("t6_id", bus.RES_ID, 1);

    // randomized traffic and ALU latency
    alu_rand = 1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (bus.GNT0) bus.REQ0 = 0;
      else if (!bus.REQ0 && $urandom_range(0, 2) == 0)
        set_req(0, 8'($urandom), 8'($urandom), 4'($urandom));
      if (bus.GNT1) bus.REQ1 = 0;
      else if (!bus.REQ1 && $urandom_range(0, 2) == 0)
        set_req(1, 8'($urandom), 8'($urandom), 4'($urandom));
    end
    bus.REQ0 = 0;
    bus.REQ1 = 0;
    repeat (40) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
